counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Receive-side monitor for the 4-bit clock_counter output bus.
- Mirrors the rst/en controls the counter sees and predicts the next count each cycle. Flags discontinuities, counts wraps and drives a status LED nibble.
- Sits beside clock_counter in top, on fpga_125mhz_clk. Gives the board a self-check of the counter.

Parameters:
- WIDTH, 4, count bus width; modulus is 2^WIDTH.
- LOCK_MATCHES, 3, consecutive correct predictions required to declare lock (range 1..15).
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 16, width of the wrap counter (wraps modulo 2^WRAP_W).

Ports:
- clk  in  1  system clock (fpga_125mhz_clk in top).
- rst  in  1  checker reset; synchronous, active-high.
- cnt_rst  in  1  same signal as the counter's rst.
- cnt_en  in  1  same signal as the counter's en.
- count_in  in  WIDTH  clock_counter out bus.
- locked  out  1  high while in LOCKED.
- err_sticky  out  1  set on the first mismatch while LOCKED; cleared only by rst.
- err_count  out  ERR_W  number of LOCKED->RESYNC transitions; saturates at all-ones.
- wrap_count  out  WRAP_W  observed MAX->0 increments while LOCKED.
- leds  out  4  {err_sticky, locked, wrap_toggle, cnt_en_q}.

Behaviour:
- Counter model: synchronous; out(t+1) = 0 if rst(t); else out(t)+1 mod 2^WIDTH if en(t); else out(t). rst has priority over en.
- Internal registers, all updated every cycle: prev_q <= count_in, cnt_rst_q <= cnt_rst, cnt_en_q <= cnt_en.
- expected = 0 if cnt_rst_q; else prev_q+1 (truncated to WIDTH, i.e. wraps) if cnt_en_q; else prev_q.
- match = (count_in == expected). Valid only when have_prev = 1.
- have_prev: cleared by rst, set on the first cycle after rst deasserts. While have_prev = 0, no comparison is made and no counter changes.
- FSM states: SEARCH, LOCKED, RESYNC.
- mcnt: 4-bit consecutive-match counter.
- SEARCH: on match, mcnt++. When mcnt reaches LOCK_MATCHES, go to LOCKED and clear mcnt. On mismatch, mcnt <= 0.
- LOCKED:
  - On mismatch: go to RESYNC; err_sticky <= 1; err_count++ unless already all-ones; mcnt <= 0.
  - On match with cnt_en_q=1, cnt_rst_q=0, prev_q = all-ones and count_in = 0: wrap_count++ (wraps) and wrap_toggle flips.
- RESYNC: same rule as SEARCH (LOCK_MATCHES consecutive matches return to LOCKED). Mismatches here do not change err_count.
- Mismatch timing: takes effect the cycle after the bad sample. locked drops in that same cycle.
- Counter reset while LOCKED: correctly predicted (expected = 0). It is not an error and not a wrap.
- Wrap caused by reset: a count of 0 following prev = all-ones with cnt_rst_q = 1 is not counted as a wrap.
- Reset values (rst=1, any state):
  - state = SEARCH.
  - mcnt, have_prev, prev_q, cnt_rst_q, cnt_en_q, err_sticky, err_count, wrap_count and wrap_toggle all 0.
  - locked = 0; leds = 0.
- Reset mid-operation: takes effect on the next edge with no partial state kept. The first post-reset sample only primes prev_q.
- Output timing: all outputs are registered. leds is a pure wiring of registered bits.

Decomposition:
- Shared package: FSM state enum (SEARCH/LOCKED/RESYNC, 2-bit encoding) and the LED bit-index constants. top and any future LED-status block reuse these.
- Sub-module: none required. The next-value predictor may be split out as counter_predict (combinational, WIDTH-parameterised) so the bench can reuse it as a reference model.

Test Plan:
- Reset release, cnt_en=1, counter free-running from 0 -> locked rises on the edge after LOCK_MATCHES(3) matches following the priming sample; err_count=0.
- Locked, cnt_en=1, count runs 14,15,0,1 -> wrap_count 0->1, leds[1] toggles, err_sticky stays 0. Repeat 70000 wraps with WRAP_W=16 -> wrap_count rolls to 4464.
- Locked, cnt_en toggled 1,0,0,1 -> holds accepted; no error, locked stays 1.
- Locked, force count_in from 5 to 9 -> next cycle locked=0, err_sticky=1, err_count=1. Inject a second glitch during RESYNC -> err_count stays 1. After 3 clean matches, locked=1.
- Locked at count 15, pulse cnt_rst one cycle -> count 0 accepted, no wrap, no error. Also force 256 LOCKED mismatches with ERR_W=8 -> err_count saturates at 255.
- Assert rst mid-RESYNC with err_count=3 -> next edge: all outputs 0, state SEARCH; relock follows the first-scenario timing.

Source files
------------

// File: rtl/counter_checker_pkg.sv
// -----------------------------------------------------------------------------
// counter_checker_pkg
// Shared definitions for the clock_counter receive-side checker. Holds the
// checker FSM state type, the width of the consecutive-match counter and the
// bit positions inside the 4-bit status LED nibble. Any block that decodes the
// LEDs should use these constants.
// -----------------------------------------------------------------------------
package counter_checker_pkg;

  // Checker FSM: hunting for lock, locked, or recovering after a mismatch.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_RESYNC = 2'd2
  } chk_state_e;

  // Consecutive-match counter width. LOCK_MATCHES must fit, so 1..15.
  localparam int MCNT_W = 4;

  // LED nibble bit positions: {err_sticky, locked, wrap_toggle, cnt_en_q}.
  localparam int LED_CNT_EN = 0;
  localparam int LED_WRAP   = 1;
  localparam int LED_LOCKED = 2;
  localparam int LED_ERR    = 3;

endpackage : counter_checker_pkg

// File: rtl/counter_checker_if.sv
// -----------------------------------------------------------------------------
// counter_checker_if
// Bundles the observed counter controls/bus and the checker status outputs.
//   cnt_rst, cnt_en : controls the monitored counter sees
//   count_in        : the counter's output bus (WIDTH bits)
//   locked, err_sticky, err_count, wrap_count, leds : checker status
// master = the side that drives the counter signals and reads status.
// slave  = the checker itself.
// -----------------------------------------------------------------------------
interface counter_checker_if #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
);

  logic              cnt_rst;
  logic              cnt_en;
  logic [WIDTH-1:0]  count_in;
  logic              locked;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_count;
  logic [WRAP_W-1:0] wrap_count;
  logic [3:0]        leds;

  modport master (
    output cnt_rst, cnt_en, count_in,
    input  locked, err_sticky, err_count, wrap_count, leds
  );

  modport slave (
    input  cnt_rst, cnt_en, count_in,
    output locked, err_sticky, err_count, wrap_count, leds
  );

endinterface : counter_checker_if

// File: rtl/counter_predict.sv
// -----------------------------------------------------------------------------
// counter_predict
// Combinational next-value model of clock_counter: given the previous count
// and the rst/en that were applied with it, produce the count that must appear
// next. rst has priority over en; the increment wraps modulo 2^WIDTH.
//   prev_i : previous count       rst_i : counter reset seen with prev_i
//   en_i   : counter enable seen with prev_i
//   next_o : predicted next count
// -----------------------------------------------------------------------------
module counter_predict #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    // NOTE: assign a default first in every combinational block so no path
    // leaves the output unassigned, which would infer a latch.
    next_o = prev_i;
    if (rst_i) begin
      next_o = '0;
    end else if (en_i) begin
      next_o = prev_i + WIDTH'(1);
    end
  end

endmodule : counter_predict

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
// Receive-side self-check for the clock_counter output bus. Each cycle it
// predicts the current count from the previous sample and the previous
// rst/en, then tracks lock with a SEARCH/LOCKED/RESYNC FSM, flags the first
// locked mismatch, counts locked->resync transitions (saturating) and counts
// genuine MAX->0 increments seen while locked.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high checker reset
//   bus  : counter_checker_if.slave
//          in : cnt_rst, cnt_en, count_in
//          out: locked, err_sticky, err_count, wrap_count,
//               leds = {err_sticky, locked, wrap_toggle, cnt_en_q}
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int LOCK_MATCHES = 3,   // 1..15
  parameter int ERR_W        = 8,
  parameter int WRAP_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  counter_checker_if.slave   bus
);

  // Sampled history of the bus and its controls.
  logic [WIDTH-1:0]  prev_q;
  logic              cnt_rst_q;
  logic              cnt_en_q;
  logic              have_prev_q;

  // FSM and status registers.
  chk_state_e        state_q,       state_d;
  logic [MCNT_W-1:0] mcnt_q,        mcnt_d;
  logic              err_sticky_q,  err_sticky_d;
  logic [ERR_W-1:0]  err_count_q,   err_count_d;
  logic [WRAP_W-1:0] wrap_count_q,  wrap_count_d;
  logic              wrap_toggle_q, wrap_toggle_d;
  logic              locked_q;

  logic [WIDTH-1:0]  expected;
  logic              match;
  logic              is_wrap;
  logic [MCNT_W-1:0] mcnt_inc;

  counter_predict #(.WIDTH(WIDTH)) u_predict (
    .prev_i (prev_q),
    .rst_i  (cnt_rst_q),
    .en_i   (cnt_en_q),
    .next_o (expected)
  );

  assign match    = (bus.count_in == expected);
  assign mcnt_inc = mcnt_q + MCNT_W'(1);

  // A real rollover: an enabled increment from all-ones to zero. A zero after
  // all-ones caused by the counter's reset is not a wrap.
  assign is_wrap  = cnt_en_q && !cnt_rst_q && (&prev_q) && (bus.count_in == '0);

  always_comb begin
    state_d       = state_q;
    mcnt_d        = mcnt_q;
    err_sticky_d  = err_sticky_q;
    err_count_d   = err_count_q;
    wrap_count_d  = wrap_count_q;
    wrap_toggle_d = wrap_toggle_q;

    // Until one sample has been primed there is nothing to compare against.
    if (have_prev_q) begin
      unique case (state_q)
        ST_SEARCH, ST_RESYNC: begin
          if (match) begin
            if (mcnt_inc == MCNT_W'(LOCK_MATCHES)) begin
              state_d = ST_LOCKED;
              mcnt_d  = '0;
            end else begin
              mcnt_d  = mcnt_inc;
            end
          end else begin
            mcnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            state_d      = ST_RESYNC;
            err_sticky_d = 1'b1;
            mcnt_d       = '0;
            if (!(&err_count_q)) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
          end else if (is_wrap) begin
            wrap_count_d  = wrap_count_q + WRAP_W'(1);
            wrap_toggle_d = !wrap_toggle_q;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          mcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= ST_SEARCH;
      mcnt_q        <= '0;
      have_prev_q   <= 1'b0;
      prev_q        <= '0;
      cnt_rst_q     <= 1'b0;
      cnt_en_q      <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      wrap_count_q  <= '0;
      wrap_toggle_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mcnt_q        <= mcnt_d;
      have_prev_q   <= 1'b1;
      prev_q        <= bus.count_in;
      cnt_rst_q     <= bus.cnt_rst;
      cnt_en_q      <= bus.cnt_en;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      wrap_count_q  <= wrap_count_d;
      wrap_toggle_q <= wrap_toggle_d;
      // Own flop so locked is glitch-free rather than a decode of state_q.
      locked_q      <= (state_d == ST_LOCKED);
    end
  end

  always_comb begin
    bus.leds             = '0;
    bus.leds[LED_ERR]    = err_sticky_q;
    bus.leds[LED_LOCKED] = locked_q;
    bus.leds[LED_WRAP]   = wrap_toggle_q;
    bus.leds[LED_CNT_EN] = cnt_en_q;
  end

  assign bus.locked     = locked_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;

endmodule : counter_checker

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
// Two checker instances share clk/rst and the counter controls:
//   inst 0: WIDTH=4, LOCK_MATCHES=3, ERR_W=8, WRAP_W=16 (board configuration)
//   inst 1: WIDTH=2, LOCK_MATCHES=1, ERR_W=8, WRAP_W=4  (short wrap counter so
//           its rollover shows up within a short run)
// The bench owns a counter per instance and drives each checker with it,
// optionally corrupting instance 0's sample. A sample-level model predicts
// every status output; a compare process checks both instances every cycle.
// -----------------------------------------------------------------------------
module tb_counter_checker;

  logic clk;
  logic rst;
  logic cnt_rst;
  logic cnt_en;
  logic [3:0] cin0;
  logic [1:0] cin1;

  counter_checker_if #(.WIDTH(4), .ERR_W(8), .WRAP_W(16)) bus0 ();
  counter_checker_if #(.WIDTH(2), .ERR_W(8), .WRAP_W(4))  bus1 ();

  assign bus0.cnt_rst  = cnt_rst;
  assign bus0.cnt_en   = cnt_en;
  assign bus0.count_in = cin0;
  assign bus1.cnt_rst  = cnt_rst;
  assign bus1.cnt_en   = cnt_en;
  assign bus1.count_in = cin1;

  counter_checker #(.WIDTH(4), .LOCK_MATCHES(3), .ERR_W(8), .WRAP_W(16)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  counter_checker #(.WIDTH(2), .LOCK_MATCHES(1), .ERR_W(8), .WRAP_W(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errs   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------- model
  // Per-instance configuration: count modulus, matches to lock, wrap modulus,
  // error saturation value.
  int P_MOD [2] = '{16, 4};
  int P_LOCK[2] = '{3, 1};
  int P_WMOD[2] = '{65536, 16};
  int P_ESAT[2] = '{255, 255};

  // Model view: last accepted sample and the controls that came with it,
  // current run of good predictions, and lifetime event totals.
  bit m_primed[2];
  int m_last  [2];
  bit m_lrst  [2];
  bit m_len   [2];
  bit m_locked[2];
  int m_streak[2];
  bit m_sticky[2];
  int m_errs  [2];
  int m_wraps [2];

  task automatic model_step(input int i, input bit r, input bit crst,
                            input bit en, input int cin);
    int  pred;
    bit  ok;
    if (r) begin
      m_primed[i] = 0; m_last[i] = 0; m_lrst[i] = 0; m_len[i] = 0;
      m_locked[i] = 0; m_streak[i] = 0; m_sticky[i] = 0;
      m_errs[i] = 0; m_wraps[i] = 0;
      return;
    end
    if (m_primed[i]) begin
      if (m_lrst[i])     pred = 0;
      else if (m_len[i]) pred = (m_last[i] + 1) % P_MOD[i];
      else               pred = m_last[i];
      ok = (cin == pred);
      if (m_locked[i]) begin
        if (!ok) begin
          m_locked[i] = 0;
          m_sticky[i] = 1;
          m_streak[i] = 0;
          if (m_errs[i] < P_ESAT[i]) m_errs[i]++;
        end else if (m_len[i] && !m_lrst[i] && m_last[i] == P_MOD[i] - 1 && cin == 0) begin
          m_wraps[i]++;
        end
      end else if (ok) begin
        m_streak[i]++;
        if (m_streak[i] >= P_LOCK[i]) begin
          m_locked[i] = 1;
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    m_primed[i] = 1;
    m_last[i]   = cin;
    m_lrst[i]   = crst;
    m_len[i]    = en;
  endtask

  function automatic int exp_leds(input int i);
    return (int'(m_sticky[i]) << 3) | (int'(m_locked[i]) << 2) |
           ((m_wraps[i] & 1) << 1) | int'(m_len[i]);
  endfunction

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("locked0",     bus0.locked,     m_locked[0]);
        check("err_sticky0", bus0.err_sticky, m_sticky[0]);
        check("err_count0",  bus0.err_count,  m_errs[0]);
        check("wrap_count0", bus0.wrap_count, m_wraps[0] % P_WMOD[0]);
        check("leds0",       bus0.leds,       exp_leds(0));
        check("locked1",     bus1.locked,     m_locked[1]);
        check("err_count1",  bus1.err_count,  m_errs[1]);
        check("wrap_count1", bus1.wrap_count, m_wraps[1] % P_WMOD[1]);
        check("leds1",       bus1.leds,       exp_leds(1));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  int cnt0 = 0;
  int cnt1 = 0;

  // One clock: present the counters (instance 0 optionally corrupted), clock,
  // then advance model and counters with what was applied.
  task automatic cyc(input bit crst, input bit en, input bit glitch);
    cnt_rst = crst;
    cnt_en  = en;
    cin0    = glitch ? 4'(cnt0 ^ 12) : 4'(cnt0);
    cin1    = 2'(cnt1);
    @(posedge clk);
    #1;
    model_step(0, rst, crst, en, int'(cin0));
    model_step(1, rst, crst, en, int'(cin1));
    if (crst) begin
      cnt0 = 0;
      cnt1 = 0;
    end else if (en) begin
      cnt0 = (cnt0 + 1) % 16;
      cnt1 = (cnt1 + 1) % 4;
    end
  endtask

  task automatic wait_lock(input int bound);
    int k = 0;
    while (!m_locked[0] && k < bound) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    n_checks++;
    if (!m_locked[0]) begin
      n_errs++;
      $display("FAIL relock_timeout: no lock after %0d cycles", bound);
    end
    check("relock0", bus0.locked, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, bus0.locked,     0);
    check({tag, "_sticky"}, bus0.err_sticky, 0);
    check({tag, "_errs"},   bus0.err_count,  0);
    check({tag, "_wraps"},  bus0.wrap_count, 0);
    check({tag, "_leds"},   bus0.leds,       0);
  endtask

  int w_before;

  initial begin
    rst     = 1'b1;
    cnt_rst = 1'b1;
    cnt_en  = 1'b0;
    cin0    = '0;
    cin1    = '0;

    // Reset state.
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    cmp_en = 1'b1;
    check_zero("reset");

    // Free-run from 0: prime + 3 matches -> locked on the 4th edge.
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    check("lock_early0", bus0.locked, 0);
    check("lock_fast1",  bus1.locked, 1);
    cyc(1'b0, 1'b1, 1'b0);
    check("lock_time0", bus0.locked, 1);
    check("lock_errs0", bus0.err_count, 0);

    // Samples 4..15, then the 15->0 rollover.
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    check("pre_wrap0", bus0.wrap_count, 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("wrap0",      bus0.wrap_count, 1);
    check("wrap_leds0", bus0.leds, 4'b0111);
    check("wrap1",      bus1.wrap_count, 4);

    // 64 more samples: instance 0 reaches 5 wraps, instance 1 reaches 20,
    // which its 4-bit wrap counter shows as 4.
    repeat (64) cyc(1'b0, 1'b1, 1'b0);
    check("wrap0_b",  bus0.wrap_count, 5);
    check("leds0_b",  bus0.leds, 4'b0111);
    check("wrap1_rl", bus1.wrap_count, 4);

    // Enable gaps: held counts are predicted.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    check("hold_locked0", bus0.locked, 1);
    check("hold_sticky0", bus0.err_sticky, 0);

    // Glitch 5 -> 9 while locked.
    for (int k = 0; k < 40 && cnt0 != 5; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check("glitch_locked0", bus0.locked, 0);
    check("glitch_sticky0", bus0.err_sticky, 1);
    check("glitch_errs0",   bus0.err_count, 1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check("resync_errs0", bus0.err_count, 1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    check("resync_early0", bus0.locked, 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("resync_lock0", bus0.locked, 1);

    // Counter reset at 15: 0 is expected, no wrap, no error.
    for (int k = 0; k < 40 && cnt0 != 15; k++) cyc(1'b0, 1'b1, 1'b0);
    w_before = m_wraps[0];
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("crst_wraps0",  bus0.wrap_count, w_before % 65536);
    check("crst_errs0",   bus0.err_count, 1);
    check("crst_locked0", bus0.locked, 1);

    // 256 locked mismatches: err_count saturates at 255.
    for (int k = 0; k < 256; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      wait_lock(20);
    end
    check("sat_errs0",   bus0.err_count, 255);
    check("sat_sticky0", bus0.err_sticky, 1);

    // Build err_count = 3, stop in RESYNC, then reset.
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    check_zero("rst_a");
    wait_lock(20);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (k < 2) wait_lock(20);
    end
    check("pre_rst_errs0",   bus0.err_count, 3);
    check("pre_rst_locked0", bus0.locked, 0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    check_zero("rst_b");
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    check("relock_early0", bus0.locked, 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("relock_time0", bus0.locked, 1);

    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors",
             n_checks, n_errs);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_counter_checker
